// File: rtl/bit_serial_adder.sv
// Bit-serial W-bit adder: one full-adder cell (two half adders plus an OR)
// processes one bit per clock, LSB first, with a carry flip-flop between bits.
// Result and carry-out are registered and held until the next completion.
module bit_serial_adder #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LastBit = CW'(W - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

    state_t        state;
    logic [W-1:0]  a_sr;
    logic [W-1:0]  b_sr;
    logic          c;
    logic [CW-1:0] cnt;

    logic          p, g, s, h, c_next;
    logic [W-1:0]  a_sr_next;

    // Full-adder bit cell on the current LSBs; sum bits refill a_sr from the top,
    // so after W shifts a_sr holds the complete sum and acts as the accumulator.
    always_comb begin
        p         = a_sr[0] ^ b_sr[0];
        g         = a_sr[0] & b_sr[0];
        s         = p ^ c;
        h         = p & c;
        c_next    = g | h;
        a_sr_next = (a_sr >> 1) | (W'(s) << (W - 1));
    end

    // Control FSM and datapath with registered busy/done/sum/cout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= StIdle;
            a_sr  <= '0;
            b_sr  <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        c     <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= StShift;
                    end
                end
                StShift: begin
                    a_sr <= a_sr_next;
                    b_sr <= b_sr >> 1;
                    c    <= c_next;
                    cnt  <= cnt + CW'(1);
                    if (cnt == LastBit) begin
                        sum   <= a_sr_next;
                        cout  <= c_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StDone;
                    end
                end
                StDone: begin
                    // Exactly one done cycle; start is ignored here.
                    done  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed self-checking bench for bit_serial_adder (W=8 and W=1 instances).
module tb_bit_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    logic         start1 = 1'b0;
    logic         a1 = 1'b0;
    logic         b1 = 1'b0;
    logic         busy1, done1, cout1;
    logic         sum1;

    int n_asserts = 0;
    int n_fail = 0;
    logic [W-1:0] prev_sum;
    logic         prev_cout;
    int           done_cnt;

    bit_serial_adder #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    bit_serial_adder #(.W(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One addition on the W=8 instance; operands are scrambled after the accept edge.
    task automatic run_add(input logic [W-1:0] va, input logic [W-1:0] vb,
                           input logic [W-1:0] exp_sum, input logic exp_cout,
                           input string tag);
        a = va;
        b = vb;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
            chk({tag, "_nodone"}, {31'b0, done}, 32'd0);
            chk({tag, "_hold_sum"}, {24'b0, sum}, {24'b0, prev_sum});
            chk({tag, "_hold_cout"}, {31'b0, cout}, {31'b0, prev_cout});
            tick();
        end
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
        chk({tag, "_busy_low"}, {31'b0, busy}, 32'd0);
        chk({tag, "_sum"}, {24'b0, sum}, {24'b0, exp_sum});
        chk({tag, "_cout"}, {31'b0, cout}, {31'b0, exp_cout});
        tick();
        chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
        prev_sum  = exp_sum;
        prev_cout = exp_cout;
    endtask

    task automatic run_add1(input logic va, input logic vb, input logic [1:0] exp,
                            input string tag);
        a1 = va;
        b1 = vb;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk({tag, "_busy"}, {31'b0, busy1}, 32'd1);
        chk({tag, "_nodone"}, {31'b0, done1}, 32'd0);
        tick();
        chk({tag, "_done"}, {31'b0, done1}, 32'd1);
        chk({tag, "_res"}, {30'b0, cout1, sum1}, {30'b0, exp});
        tick();
        chk({tag, "_done_pulse"}, {31'b0, done1}, 32'd0);
    endtask

    initial begin
        // 1) async reset takes effect between edges
        #1 rst = 1'b1;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_sum", {24'b0, sum}, 32'd0);
        chk("rst_cout", {31'b0, cout}, 32'd0);
        chk("rst1_res", {29'b0, busy1, cout1, sum1}, 32'd0);
        #10 rst = 1'b0;
        prev_sum  = '0;
        prev_cout = 1'b0;
        tick();

        // 2) and 3) directed additions
        run_add(8'h35, 8'h4A, 8'h7F, 1'b0, "add_35_4a");
        run_add(8'hFF, 8'h01, 8'h00, 1'b1, "add_ff_01");
        run_add(8'hFF, 8'hFF, 8'hFE, 1'b1, "add_ff_ff");

        // 4) start held for 20 edges; accepts at edges 0 and 10, operands change every cycle
        a = 8'h12;
        b = 8'h34;
        start = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hold_busy", {31'b0, busy},
                ((i <= 7) || (i >= 10 && i <= 17)) ? 32'd1 : 32'd0);
            chk("hold_done", {31'b0, done}, (i == 8 || i == 18) ? 32'd1 : 32'd0);
            if (done) done_cnt++;
            if (i == 8) begin
                chk("hold_sum0", {24'b0, sum}, 32'h46);
                chk("hold_cout0", {31'b0, cout}, 32'd0);
            end
            if (i == 18) begin
                chk("hold_sum1", {24'b0, sum}, 32'h08);
                chk("hold_cout1", {31'b0, cout}, 32'd1);
            end
            a = 8'(8'hC0 + i);
            b = 8'(8'h07 * i);
        end
        start = 1'b0;
        tick();
        chk("hold_done_count", done_cnt, 32'd2);
        chk("hold_idle", {31'b0, busy}, 32'd0);

        // 5) reset at cycle 4 of SHIFT aborts; sum/cout clear immediately
        a = 8'h35;
        b = 8'h4A;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("abort_busy_pre", {31'b0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_sum", {24'b0, sum}, 32'd0);
        chk("abort_cout", {31'b0, cout}, 32'd0);
        #1 rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) done_cnt++;
        end
        chk("abort_quiet", done_cnt, 32'd0);
        prev_sum  = '0;
        prev_cout = 1'b0;
        run_add(8'h5A, 8'hA5, 8'hFF, 1'b0, "add_after_abort");
        run_add(8'h80, 8'h80, 8'h00, 1'b1, "add_80_80");

        // 6) W=1 instance truth table
        run_add1(1'b0, 1'b0, 2'b00, "w1_00");
        run_add1(1'b0, 1'b1, 2'b01, "w1_01");
        run_add1(1'b1, 1'b0, 2'b01, "w1_10");
        run_add1(1'b1, 1'b1, 2'b10, "w1_11");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
